// File: rtl/divby_sweep_ctrl.sv
// Sweeps an inclusive range [lo, hi] through an external divisible-by-3-or-5 checker,
// streams every matching value over valid/ready, counts matches and pulses done at the end.
module divby_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] chk_val,
  input  logic             chk_hit,
  output logic [WIDTH-1:0] out_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    EMIT  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] cur, cur_d;
  logic [WIDTH-1:0] out_val_q, out_val_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      cur         <= '0;
      out_val_q   <= '0;
      out_valid_q <= 1'b0;
      hit_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cur         <= cur_d;
      out_val_q   <= out_val_d;
      out_valid_q <= out_valid_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
    end
  end

  // cur is compared with hi_q before it is incremented, so the sweep never wraps past the top.
  always_comb begin
    state_d     = state;
    lo_d        = lo_q;
    hi_d        = hi_q;
    cur_d       = cur;
    out_val_d   = out_val_q;
    out_valid_d = out_valid_q;
    hit_d       = hit_q;
    err_d       = err_q;

    case (state)
      IDLE: begin
        if (start) begin
          lo_d  = lo;
          hi_d  = hi;
          hit_d = '0;
          err_d = 1'b0;
          if (lo > hi) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            cur_d   = lo;
            state_d = PROBE;
          end
        end
      end
      PROBE: begin
        if (chk_hit) begin
          out_val_d   = cur;
          out_valid_d = 1'b1;
          hit_d       = hit_q + CNT_W'(1);
          state_d     = EMIT;
        end else if (cur == hi_q) begin
          state_d = FIN;
        end else begin
          cur_d = cur + WIDTH'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (cur == hi_q) begin
            state_d = FIN;
          end else begin
            cur_d   = cur + WIDTH'(1);
            state_d = PROBE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign chk_val   = cur;
  assign out_val   = out_val_q;
  assign out_valid = out_valid_q;
  assign hit_count = hit_q;
  assign err       = err_q;
  assign busy      = (state == PROBE) || (state == EMIT);
  assign done      = (state == FIN);

endmodule
